// File: rtl/mem_port_arbiter_if.sv
// Core-side fetch/data request ports and memory-side access port for mem_port_arbiter.
// slave = arbiter view, master = the core/RAM environment driving it.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic [DATA_WIDTH-1:0] if_rdata_o;
    logic                  if_valid_o;

    logic                  d_req_i;
    logic                  d_we_i;
    logic [ADDR_WIDTH-1:0] d_addr_i;
    logic [DATA_WIDTH-1:0] d_wdata_i;
    logic [DATA_WIDTH-1:0] d_rdata_o;
    logic                  d_valid_o;

    logic                  mem_en_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    logic                  stall_o;

    modport slave (
        input  if_req_i, if_addr_i,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
        input  mem_rdata_i,
        output if_rdata_o, if_valid_o,
        output d_rdata_o, d_valid_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output stall_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i,
        output mem_rdata_i,
        input  if_rdata_o, if_valid_o,
        input  d_rdata_o, d_valid_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  stall_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin share of one single-port sync RAM between fetch and load/store ports.
// Latency: issue combinational in cycle N, per-port valid pulse registered in N+1.
// Backpressure: stall_o holds the core while any request lacks its valid pulse.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_D    = 2'd2
    } resp_t;

    resp_t resp_q;
    logic  last_d_q;   // 1 = data port won the most recent grant
    logic  resp_we_q;  // pending data response is a write ack

    logic if_elig;
    logic d_elig;
    logic grant_if;
    logic grant_d;

    // A port in its response cycle is masked so it cannot re-issue back to back.
    always_comb begin
        if_elig  = bus.if_req_i & (resp_q != RESP_IF) & ~rst;
        d_elig   = bus.d_req_i  & (resp_q != RESP_D)  & ~rst;
        grant_if = if_elig & (~d_elig | last_d_q);
        grant_d  = d_elig & ~grant_if;
    end

    always_comb begin
        bus.mem_en_o    = grant_if | grant_d;
        bus.mem_we_o    = grant_d & bus.d_we_i;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        if (grant_if) begin
            bus.mem_addr_o = bus.if_addr_i;
        end else if (grant_d) begin
            bus.mem_addr_o = bus.d_addr_i;
            if (bus.d_we_i) begin
                bus.mem_wdata_o = bus.d_wdata_i;
            end
        end
    end

    always_comb begin
        bus.if_valid_o = (resp_q == RESP_IF);
        bus.d_valid_o  = (resp_q == RESP_D);
        bus.if_rdata_o = bus.if_valid_o ? bus.mem_rdata_i : '0;
        bus.d_rdata_o  = (bus.d_valid_o && !resp_we_q) ? bus.mem_rdata_i : '0;
        bus.stall_o    = (bus.if_req_i & ~bus.if_valid_o) | (bus.d_req_i & ~bus.d_valid_o);
    end

    // Reset favours fetch on the first tie by pretending data won last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_q    <= RESP_NONE;
            last_d_q  <= 1'b1;
            resp_we_q <= 1'b0;
        end else if (grant_if) begin
            resp_q    <= RESP_IF;
            last_d_q  <= 1'b0;
            resp_we_q <= 1'b0;
        end else if (grant_d) begin
            resp_q    <= RESP_D;
            last_d_q  <= 1'b1;
            resp_we_q <= bus.d_we_i;
        end else begin
            resp_q    <= RESP_NONE;
            resp_we_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle-latency RAM.
// Inputs change 1 time unit after the rising edge; outputs are checked 2 units later.
module tb_mem_port_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] ram_rdata = '0;
    logic          pre_en    = 1'b0;
    logic [AW-1:0] pre_addr  = '0;
    logic [DW-1:0] pre_dat   = '0;

    always @(posedge clk) begin
        if (pre_en) begin
            ram[pre_addr] <= pre_dat;
        end else if (bus.mem_en_o) begin
            if (bus.mem_we_o) ram[bus.mem_addr_o] <= bus.mem_wdata_o;
            else              ram_rdata <= ram[bus.mem_addr_o];
        end
    end
    assign bus.mem_rdata_i = ram_rdata;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        next_cycle();
        pre_en   = 1'b1;
        pre_addr = a;
        pre_dat  = d;
    endtask

    initial begin
        bus.if_req_i  = 1'b0;
        bus.if_addr_i = '0;
        bus.d_req_i   = 1'b0;
        bus.d_we_i    = 1'b0;
        bus.d_addr_i  = '0;
        bus.d_wdata_i = '0;

        preload(10'h004, 32'hA5A5_0004);
        preload(10'h010, 32'h0050_0093);
        preload(10'h020, 32'h1111_2222);
        preload(10'h100, 32'h3333_4444);
        next_cycle();
        pre_en = 1'b0;

        // Reset held with both requests high
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 10'h004;
        bus.d_req_i   = 1'b1;
        bus.d_we_i    = 1'b0;
        bus.d_addr_i  = 10'h100;
        settle();
        chk("rst_mem_en",  bus.mem_en_o,   0);
        chk("rst_mem_we",  bus.mem_we_o,   0);
        chk("rst_mem_addr", bus.mem_addr_o, 0);
        chk("rst_if_valid", bus.if_valid_o, 0);
        chk("rst_d_valid", bus.d_valid_o,  0);
        chk("rst_stall",   bus.stall_o,    1);

        // Release: simultaneous requests, fetch wins the first tie
        next_cycle();
        rst = 1'b0;
        settle();
        chk("tie0_mem_en",  bus.mem_en_o,   1);
        chk("tie0_addr",    bus.mem_addr_o, 10'h004);
        chk("tie0_we",      bus.mem_we_o,   0);
        next_cycle();
        settle();
        chk("tie1_if_valid", bus.if_valid_o, 1);
        chk("tie1_if_rdata", bus.if_rdata_o, 32'hA5A5_0004);
        chk("tie1_d_issue",  bus.mem_addr_o, 10'h100);
        chk("tie1_stall",    bus.stall_o,    1);
        next_cycle();
        bus.if_req_i = 1'b0;
        settle();
        chk("tie2_d_valid", bus.d_valid_o, 1);
        chk("tie2_d_rdata", bus.d_rdata_o, 32'h3333_4444);
        chk("tie2_mem_en",  bus.mem_en_o,  0);
        chk("tie2_stall",   bus.stall_o,   0);
        next_cycle();
        bus.d_req_i = 1'b0;
        settle();
        chk("idle_mem_en", bus.mem_en_o,  0);
        chk("idle_d_valid", bus.d_valid_o, 0);
        chk("idle_d_rdata", bus.d_rdata_o, 0);

        // Single held fetch: one access every 2 cycles
        next_cycle();
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 10'h010;
        settle();
        chk("sf0_mem_en", bus.mem_en_o,   1);
        chk("sf0_addr",   bus.mem_addr_o, 10'h010);
        chk("sf0_stall",  bus.stall_o,    1);
        next_cycle();
        settle();
        chk("sf1_valid",  bus.if_valid_o, 1);
        chk("sf1_rdata",  bus.if_rdata_o, 32'h0050_0093);
        chk("sf1_mem_en", bus.mem_en_o,   0);
        next_cycle();
        settle();
        chk("sf2_valid",  bus.if_valid_o, 0);
        chk("sf2_rdata",  bus.if_rdata_o, 0);
        chk("sf2_mem_en", bus.mem_en_o,   1);
        next_cycle();
        settle();
        chk("sf3_valid",  bus.if_valid_o, 1);
        next_cycle();
        bus.if_req_i = 1'b0;
        settle();
        chk("sf4_mem_en", bus.mem_en_o, 0);

        // Data write to top address
        next_cycle();
        bus.d_req_i   = 1'b1;
        bus.d_we_i    = 1'b1;
        bus.d_addr_i  = 10'h3FF;
        bus.d_wdata_i = 32'hDEAD_BEEF;
        settle();
        chk("wr0_mem_en", bus.mem_en_o,    1);
        chk("wr0_we",     bus.mem_we_o,    1);
        chk("wr0_addr",   bus.mem_addr_o,  10'h3FF);
        chk("wr0_wdata",  bus.mem_wdata_o, 32'hDEAD_BEEF);
        next_cycle();
        settle();
        chk("wr1_d_valid", bus.d_valid_o,   1);
        chk("wr1_d_rdata", bus.d_rdata_o,   0);
        chk("wr1_we",      bus.mem_we_o,    0);
        chk("wr1_wdata",   bus.mem_wdata_o, 0);
        next_cycle();
        bus.d_req_i   = 1'b0;
        bus.d_we_i    = 1'b0;
        bus.d_wdata_i = '0;
        settle();
        chk("wr2_d_valid", bus.d_valid_o, 0);

        // Contention: last grant was data, so fetch leads, then strict alternation
        next_cycle();
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 10'h020;
        bus.d_req_i   = 1'b1;
        bus.d_addr_i  = 10'h100;
        settle();
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("ct%0d_mem_en", i),   bus.mem_en_o,   1);
            chk($sformatf("ct%0d_addr", i),     bus.mem_addr_o, (i % 2 == 0) ? 10'h020 : 10'h100);
            chk($sformatf("ct%0d_if_valid", i), bus.if_valid_o, (i % 2 == 1) ? 1 : 0);
            chk($sformatf("ct%0d_d_valid", i),  bus.d_valid_o,  (i % 2 == 0 && i > 0) ? 1 : 0);
            if (i % 2 == 1) chk($sformatf("ct%0d_if_rdata", i), bus.if_rdata_o, 32'h1111_2222);
            if (i % 2 == 0 && i > 0) chk($sformatf("ct%0d_d_rdata", i), bus.d_rdata_o, 32'h3333_4444);
            next_cycle();
            settle();
        end
        bus.if_req_i = 1'b0;
        bus.d_req_i  = 1'b0;
        #0;
        chk("ct6_d_valid", bus.d_valid_o, 1);
        chk("ct6_mem_en",  bus.mem_en_o,  0);
        next_cycle();
        settle();

        // Read-after-write
        bus.d_req_i   = 1'b1;
        bus.d_we_i    = 1'b1;
        bus.d_addr_i  = 10'h080;
        bus.d_wdata_i = 32'h1234_5678;
        #0;
        chk("raw_w_we", bus.mem_we_o, 1);
        next_cycle();
        settle();
        chk("raw_w_valid", bus.d_valid_o, 1);
        next_cycle();
        bus.d_we_i    = 1'b0;
        bus.d_wdata_i = '0;
        settle();
        chk("raw_r_en",   bus.mem_en_o,   1);
        chk("raw_r_we",   bus.mem_we_o,   0);
        chk("raw_r_addr", bus.mem_addr_o, 10'h080);
        next_cycle();
        settle();
        chk("raw_r_valid", bus.d_valid_o, 1);
        chk("raw_r_rdata", bus.d_rdata_o, 32'h1234_5678);
        next_cycle();
        bus.d_req_i = 1'b0;
        settle();

        // Reset in the response cycle of a fetch drops its valid pulse
        next_cycle();
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 10'h004;
        settle();
        chk("mr0_addr", bus.mem_addr_o, 10'h004);
        next_cycle();
        rst = 1'b1;
        settle();
        chk("mr1_if_valid", bus.if_valid_o, 0);
        chk("mr1_if_rdata", bus.if_rdata_o, 0);
        chk("mr1_mem_en",   bus.mem_en_o,   0);
        next_cycle();
        bus.d_req_i  = 1'b1;
        bus.d_addr_i = 10'h100;
        rst = 1'b0;
        settle();
        chk("mr2_tie_addr", bus.mem_addr_o, 10'h004);
        chk("mr2_if_valid", bus.if_valid_o, 0);
        next_cycle();
        settle();
        chk("mr3_if_valid", bus.if_valid_o, 1);
        chk("mr3_if_rdata", bus.if_rdata_o, 32'hA5A5_0004);
        chk("mr3_d_addr",   bus.mem_addr_o, 10'h100);
        next_cycle();
        bus.if_req_i = 1'b0;
        settle();
        chk("mr4_d_valid", bus.d_valid_o, 1);
        next_cycle();
        bus.d_req_i = 1'b0;
        settle();

        // Request dropped before its valid still completes
        next_cycle();
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 10'h010;
        settle();
        chk("drop0_en", bus.mem_en_o, 1);
        next_cycle();
        bus.if_req_i = 1'b0;
        settle();
        chk("drop1_valid", bus.if_valid_o, 1);
        chk("drop1_rdata", bus.if_rdata_o, 32'h0050_0093);
        chk("drop1_stall", bus.stall_o,    0);
        next_cycle();
        settle();
        chk("drop2_valid", bus.if_valid_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
